alu_result_tx_sequencer: RTL and testbench
==========================================

Name: alu_result_tx_sequencer

Overview:
Sequences ALU results back to the host over the UART transmitter. It captures each result word and its flags when `result_valid` pulses. It then serialises them into bytes, handshaking with the UART TX core one byte at a time. A one-entry pending buffer absorbs a result that arrives mid-transmission; further arrivals are dropped and flagged as overrun. It sits between the ALU output (driven after the operand/command receive path asserts its ready pulse) and the UART TX core.

Parameters:
- `DATA_W`, default 16: result width in bits. Must be a multiple of 8, from 8 to 32.
- `FLAGS_EN`, default 1: when 1, a flags byte `{4'b0, flags}` is sent after the result bytes.
- `LSB_FIRST`, default 1: 1 sends the low result byte first; 0 sends the high byte first.
- `BUSY_TIMEOUT`, default 16: maximum cycles to wait for `tx_busy` to rise after `tx_start`.

Ports:
- `clock`  input  1  system clock; all logic on posedge.
- `reset`  input  1  synchronous, active-low (0 = reset).
- `result`  input  DATA_W  ALU result; sampled only when `result_valid`=1.
- `flags`  input  4  ALU flags {carry, overflow, negative, zero}; sampled with `result`.
- `result_valid`  input  1  one-cycle pulse marking a new result.
- `clear_overrun`  input  1  clears the sticky `overrun` flag.
- `tx_data`  output  8  byte presented to the UART TX core.
- `tx_start`  output  1  one-cycle request to transmit `tx_data`.
- `tx_busy`  input  1  UART TX core busy.
- `busy`  output  1  high while any byte is in flight or pending.
- `overrun`  output  1  sticky; a result was dropped.
- `timeout_err`  output  1  sticky; `tx_busy` never rose after a start. Cleared by `clear_overrun`.

Behaviour:
- Constants:
  - NBYTES = DATA_W/8 + FLAGS_EN.
  - Byte index counter is $clog2(NBYTES+1) bits wide.
- Reset (reset=0 at a clock edge):
  - State goes to IDLE.
  - `tx_data`=0, `tx_start`=0, `busy`=0, `overrun`=0, `timeout_err`=0.
  - Pending buffer emptied; byte index=0; timeout counter=0.
  - Reset asserted mid-transfer abandons the frame immediately; no further `tx_start` until a new `result_valid`.
- Shift register: holds {flags byte, result} and is loaded on capture.
  - Byte k (k < DATA_W/8) is `result[8k+7:8k]` when LSB_FIRST=1, otherwise `result[DATA_W-1-8k -: 8]`.
  - Byte DATA_W/8 is the flags byte.
- FSM states:
  - IDLE: on `result_valid`, load the shift register and go to START. Clear the index on the next edge.
  - START: wait for `tx_busy`=0. Then drive `tx_start`=1 for exactly one cycle with `tx_data`=byte[index], and go to WAIT_HI.
  - WAIT_HI: `tx_data` is held stable. On `tx_busy`=1 go to WAIT_LO. If BUSY_TIMEOUT cycles pass without `tx_busy`, set `timeout_err` and go to WAIT_LO (the byte counts as sent).
  - WAIT_LO: on `tx_busy`=0, increment the index.
    - If index = NBYTES-1 and the pending buffer is full: move pending into the shift register, clear pending, index=0, go to START (no IDLE cycle).
    - If index = NBYTES-1 and pending is empty: go to IDLE.
    - Otherwise: go to START.
- Latency: `result_valid` at edge N gives the first `tx_start` at edge N+2, provided `tx_busy`=0.
- Pending buffer (one entry):
  - `result_valid` while state≠IDLE with pending empty: capture into pending.
  - With pending full: drop the new result and set `overrun`.
  - `result_valid` in the same cycle pending is consumed (WAIT_LO final byte): the new value goes into pending (now empty). No overrun.
- `busy` = (state≠IDLE) | pending_full.
- `clear_overrun` and a new overrun in the same cycle: the set wins.
- `tx_start` is never asserted while `tx_busy`=1.
- `tx_start` is never asserted on two consecutive cycles.

Decomposition:
- Package `alu_tx_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} tx_seq_state_t`.
  - FLAGS_BYTE_PAD constant.
  - Flag bit-position localparams.
- Sub-module `tx_pending_buf`: single-entry holding register with `push`, `pop`, `full`, `drop` outputs. Keeps the overrun and simultaneous push/pop rules isolated and separately testable.

Test Plan:
- Default parameters, result=16'hA55A, flags=4'b0101, UART model with busy 1 cycle after start for 10 cycles → `tx_data` sequence 8'h5A, 8'hA5, 8'h05; exactly 3 `tx_start` pulses; `busy` falls 1 cycle after the last `tx_busy` fall.
- LSB_FIRST=0, FLAGS_EN=0, result=16'h1234 → bytes 8'h12, 8'h34; no flags byte.
- result_valid 16'h0001 then 16'h0002 mid-frame, then 16'h0003 while pending is full → frames for 1 and 2 sent back-to-back with no IDLE cycle; 3 dropped; `overrun`=1 until `clear_overrun`.
- UART model never raises `tx_busy` → after 16 cycles `timeout_err`=1; the sequencer advances and completes the frame; clearing works.
- reset=0 asserted during the second byte → next edge: IDLE, all outputs 0, pending empty; no `tx_start` until a new `result_valid`.
- `tx_busy` held high at capture → `tx_start` withheld until `tx_busy`=0, then asserted the next cycle.

Source files
------------

// File: rtl/alu_result_tx_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// alu_tx_pkg : shared types and constants for the ALU result TX sequencer
// Revision   : 1.0
// ============================================================================
package alu_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_seq_state_t;

    // Upper nibble of the flags byte on the wire
    localparam logic [3:0] FLAGS_BYTE_PAD = 4'b0000;

    localparam int FLAG_ZERO_BIT     = 0;
    localparam int FLAG_NEGATIVE_BIT = 1;
    localparam int FLAG_OVERFLOW_BIT = 2;
    localparam int FLAG_CARRY_BIT    = 3;

endpackage
`default_nettype wire

// File: rtl/alu_result_tx_sequencer_pending_buf.sv
`default_nettype none
// ============================================================================
// tx_pending_buf : single-entry holding register; drop flags a push into a full slot
// Revision       : 1.0
// ============================================================================
module tx_pending_buf #(
    parameter int WIDTH = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             drop
);
    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // A push in the same cycle as a pop reuses the freed slot
    assign drop     = push && r_full && !pop;
    assign full     = r_full;
    assign pop_data = r_data;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (pop) begin
            r_full <= push;
            if (push) begin
                r_data <= push_data;
            end
        end else if (push && !r_full) begin
            r_full <= 1'b1;
            r_data <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_result_tx_sequencer.sv
`default_nettype none
// ============================================================================
// alu_result_tx_sequencer : serialises captured ALU results into UART TX bytes
// Revision                : 1.0
// ============================================================================
module alu_result_tx_sequencer
    import alu_tx_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int FLAGS_EN     = 1,
    parameter int LSB_FIRST    = 1,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] result,
    input  logic [3:0]        flags,
    input  logic              result_valid,
    input  logic              clear_overrun,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);
    localparam int RBYTES = DATA_W / 8;
    localparam int NBYTES = RBYTES + FLAGS_EN;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam int TO_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam int CAP_W  = DATA_W + 4;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  c_to_last  = TO_W'(BUSY_TIMEOUT - 1);

    tx_seq_state_t              r_state;
    logic [DATA_W+7:0]          r_sr;
    logic [IDX_W-1:0]           r_index;
    logic [TO_W-1:0]            r_to_cnt;
    logic [7:0]                 r_tx_data;
    logic                       r_tx_start;
    logic                       r_overrun;
    logic                       r_timeout_err;

    logic [CAP_W-1:0]           w_capture;
    logic [CAP_W-1:0]           w_pend_data;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_pend_full;
    logic                       w_drop;
    logic                       w_last;
    logic                       w_to_hit;
    logic [(1<<IDX_W)-1:0][7:0] w_bytes;

    function automatic logic [DATA_W+7:0] sr_image(input logic [CAP_W-1:0] cap);
        return {FLAGS_BYTE_PAD, cap[CAP_W-1 -: 4], cap[DATA_W-1:0]};
    endfunction

    assign w_capture = {flags[FLAG_CARRY_BIT:FLAG_ZERO_BIT], result};
    assign w_last    = (r_index == c_last_idx);
    assign w_to_hit  = (r_state == WAIT_HI) && !tx_busy && (r_to_cnt == c_to_last);
    // Pending is also drained from IDLE: a result can land there on the final-byte edge
    assign w_push    = result_valid && ((r_state != IDLE) || w_pend_full);
    assign w_pop     = w_pend_full &&
                       ((r_state == IDLE) || ((r_state == WAIT_LO) && !tx_busy && w_last));

    for (genvar k = 0; k < (1 << IDX_W); k++) begin : g_bytes
        if (k < RBYTES) begin : g_res
            if (LSB_FIRST != 0) begin : g_lsb
                assign w_bytes[k] = r_sr[8*k +: 8];
            end else begin : g_msb
                assign w_bytes[k] = r_sr[DATA_W-8-8*k +: 8];
            end
        end else if ((k == RBYTES) && (FLAGS_EN != 0)) begin : g_flags
            assign w_bytes[k] = r_sr[DATA_W +: 8];
        end else begin : g_zero
            assign w_bytes[k] = 8'h00;
        end
    end

    tx_pending_buf #(
        .WIDTH (CAP_W)
    ) u_pending (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_capture),
        .pop_data  (w_pend_data),
        .full      (w_pend_full),
        .drop      (w_drop)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_sr          <= '0;
            r_index       <= '0;
            r_to_cnt      <= '0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end

            if (w_to_hit) begin
                r_timeout_err <= 1'b1;
            end else if (clear_overrun) begin
                r_timeout_err <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_index <= '0;
                    if (w_pend_full) begin
                        r_sr    <= sr_image(w_pend_data);
                        r_state <= START;
                    end else if (result_valid) begin
                        r_sr    <= sr_image(w_capture);
                        r_state <= START;
                    end
                end
                START: begin
                    r_to_cnt <= '0;
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_bytes[r_index];
                        r_state    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    // A missing busy pulse is treated as a completed byte
                    if (tx_busy || w_to_hit) begin
                        r_state <= WAIT_LO;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (w_last) begin
                            r_index <= '0;
                            if (w_pend_full) begin
                                r_sr    <= sr_image(w_pend_data);
                                r_state <= START;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= START;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign busy        = (r_state != IDLE) || w_pend_full;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_tx_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_result_tx_sequencer : directed vectors and corner-case sequences
// Revision                   : 1.0
// ============================================================================
module tb_alu_result_tx_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    // instance A: default parameters
    logic [15:0] result_a;
    logic [3:0]  flags_a;
    logic        rv_a, clr_a;
    logic [7:0]  tx_data_a;
    logic        tx_start_a, tx_busy_a, busy_a, overrun_a, toerr_a;

    // instance B: MSB first, no flags byte
    logic [15:0] result_b;
    logic [3:0]  flags_b;
    logic        rv_b, clr_b;
    logic [7:0]  tx_data_b;
    logic        tx_start_b, tx_busy_b, busy_b, overrun_b, toerr_b;

    alu_result_tx_sequencer u_dut_a (
        .clock(clock), .reset(reset), .result(result_a), .flags(flags_a),
        .result_valid(rv_a), .clear_overrun(clr_a), .tx_data(tx_data_a),
        .tx_start(tx_start_a), .tx_busy(tx_busy_a), .busy(busy_a),
        .overrun(overrun_a), .timeout_err(toerr_a)
    );

    alu_result_tx_sequencer #(.LSB_FIRST(0), .FLAGS_EN(0)) u_dut_b (
        .clock(clock), .reset(reset), .result(result_b), .flags(flags_b),
        .result_valid(rv_b), .clear_overrun(clr_b), .tx_data(tx_data_b),
        .tx_start(tx_start_b), .tx_busy(tx_busy_b), .busy(busy_b),
        .overrun(overrun_b), .timeout_err(toerr_b)
    );

    // UART models: busy rises one cycle after start is seen
    logic       never_a = 1'b0, force_busy_a = 1'b0;
    logic       arm_a, bm_a, arm_b, bm_b;
    logic [3:0] cnt_a, cnt_b;

    always @(posedge clock) begin
        if (!reset) begin
            arm_a <= 1'b0; bm_a <= 1'b0; cnt_a <= 4'd0;
            arm_b <= 1'b0; bm_b <= 1'b0; cnt_b <= 4'd0;
        end else begin
            if (arm_a) begin bm_a <= 1'b1; cnt_a <= 4'd9; end
            else if (bm_a) begin if (cnt_a == 4'd0) bm_a <= 1'b0; else cnt_a <= cnt_a - 4'd1; end
            arm_a <= tx_start_a && !never_a;
            if (arm_b) begin bm_b <= 1'b1; cnt_b <= 4'd2; end
            else if (bm_b) begin if (cnt_b == 4'd0) bm_b <= 1'b0; else cnt_b <= cnt_b - 4'd1; end
            arm_b <= tx_start_b;
        end
    end
    assign tx_busy_a = bm_a | force_busy_a;
    assign tx_busy_b = bm_b;

    // Monitor: captured bytes, start/fall cycle stamps, protocol violations
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         sc[$];
    int         fc[$];
    int         cyc = 0, bfall = 0, proto_bad = 0;
    logic       prev_txb = 1'b0, prev_busy = 1'b0, prev_start_a = 1'b0, prev_start_b = 1'b0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            if (tx_start_a) begin qa.push_back(tx_data_a); sc.push_back(cyc); end
            if (tx_start_b) qb.push_back(tx_data_b);
            if (prev_txb && !tx_busy_a) fc.push_back(cyc);
            if (prev_busy && !busy_a) bfall <= cyc;
            if ((tx_start_a && (tx_busy_a || prev_start_a)) ||
                (tx_start_b && (tx_busy_b || prev_start_b)))
                proto_bad <= proto_bad + 1;
        end
        prev_txb     <= tx_busy_a;
        prev_busy    <= busy_a;
        prev_start_a <= tx_start_a;
        prev_start_b <= tx_start_b;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pulse_a(input logic [15:0] r, input logic [3:0] f);
        result_a = r; flags_a = f; rv_a = 1'b1;
        step();
        rv_a = 1'b0;
    endtask

    task automatic wait_idle_a(input int max);
        int n = 0;
        while (busy_a && n < max) begin step(); n++; end
        chk("idle_wait_a", 32'(busy_a), 32'd0);
        step();
    endtask

    task automatic wait_start_a(input int max);
        int n = 0;
        while (!tx_start_a && n < max) begin step(); n++; end
        chk("start_wait_a", 32'(tx_start_a), 32'd1);
    endtask

    typedef struct {
        logic [15:0] res;
        logic [3:0]  fl;
        logic [7:0]  b0, b1, b2;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] exp_bytes[9];
    int         base, s0, f0, falls, n;
    logic       prev;

    initial begin
        vecs[0] = '{res: 16'hA55A, fl: 4'b0101, b0: 8'h5A, b1: 8'hA5, b2: 8'h05};
        vecs[1] = '{res: 16'h1234, fl: 4'b1000, b0: 8'h34, b1: 8'h12, b2: 8'h08};
        vecs[2] = '{res: 16'h00FF, fl: 4'b0000, b0: 8'hFF, b1: 8'h00, b2: 8'h00};
        vecs[3] = '{res: 16'hFFFF, fl: 4'b1111, b0: 8'hFF, b1: 8'hFF, b2: 8'h0F};

        reset = 1'b0;
        result_a = '0; flags_a = '0; rv_a = 1'b0; clr_a = 1'b0;
        result_b = '0; flags_b = 4'hF; rv_b = 1'b0; clr_b = 1'b0;
        repeat (3) step();
        chk("rst_tx_start", 32'(tx_start_a), 32'd0);
        chk("rst_tx_data",  32'(tx_data_a),  32'd0);
        chk("rst_busy",     32'(busy_a),     32'd0);
        chk("rst_overrun",  32'(overrun_a),  32'd0);
        chk("rst_timeout",  32'(toerr_a),    32'd0);
        chk("rst_busy_b",   32'(busy_b),     32'd0);
        reset = 1'b1;
        step();

        // Table-driven frames: latency, byte order, flags byte, busy fall
        for (int i = 0; i < 4; i++) begin
            base = qa.size();
            pulse_a(vecs[i].res, vecs[i].fl);
            chk("lat_edge_n1", 32'(tx_start_a), 32'd0);
            step();
            chk("lat_edge_n2", 32'(tx_start_a), 32'd1);
            chk("first_byte",  32'(tx_data_a),  32'(vecs[i].b0));
            wait_idle_a(200);
            chk("frame_len", 32'(qa.size() - base), 32'd3);
            if (qa.size() - base == 3) begin
                chk("byte0", 32'(qa[base]),     32'(vecs[i].b0));
                chk("byte1", 32'(qa[base + 1]), 32'(vecs[i].b1));
                chk("byte2", 32'(qa[base + 2]), 32'(vecs[i].b2));
            end
            chk("busy_fall_delay", 32'(bfall - fc[fc.size() - 1]), 32'd1);
        end

        // Pending buffer, with a new result landing on the pop edge
        base = qa.size(); s0 = sc.size(); f0 = fc.size();
        pulse_a(16'h0001, 4'h0);
        wait_start_a(10);
        pulse_a(16'h0002, 4'h0);
        falls = 0; n = 0; prev = tx_busy_a;
        while (falls < 3 && n < 200) begin
            step(); n++;
            if (prev && !tx_busy_a) falls++;
            prev = tx_busy_a;
        end
        chk("pend_falls", 32'(falls), 32'd3);
        pulse_a(16'h0003, 4'h0);
        chk("pop_push_no_overrun", 32'(overrun_a), 32'd0);
        wait_idle_a(400);
        exp_bytes = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00};
        chk("pend_len", 32'(qa.size() - base), 32'd9);
        if (qa.size() - base == 9)
            for (int k = 0; k < 9; k++) chk("pend_byte", 32'(qa[base + k]), 32'(exp_bytes[k]));
        if (sc.size() - s0 == 9 && fc.size() - f0 == 9) begin
            chk("b2b_gap_1", 32'(sc[s0 + 3] - fc[f0 + 2]), 32'd2);
            chk("b2b_gap_2", 32'(sc[s0 + 6] - fc[f0 + 5]), 32'd2);
        end else begin
            chk("b2b_stamps", 32'(sc.size() - s0), 32'd9);
        end

        // Overrun: third result while pending is full
        base = qa.size();
        pulse_a(16'h0004, 4'h0);
        wait_start_a(10);
        pulse_a(16'h0005, 4'h0);
        chk("no_overrun_yet", 32'(overrun_a), 32'd0);
        pulse_a(16'h0006, 4'h0);
        chk("overrun_set", 32'(overrun_a), 32'd1);
        wait_idle_a(400);
        chk("ovr_len", 32'(qa.size() - base), 32'd6);
        if (qa.size() - base == 6) begin
            chk("ovr_first",  32'(qa[base]),     32'h04);
            chk("ovr_second", 32'(qa[base + 3]), 32'h05);
        end
        chk("overrun_sticky", 32'(overrun_a), 32'd1);
        clr_a = 1'b1; step(); clr_a = 1'b0;
        chk("overrun_clear", 32'(overrun_a), 32'd0);

        // Busy never rises: timeout after 16 cycles in WAIT_HI
        never_a = 1'b1;
        base = qa.size();
        pulse_a(16'hBEEF, 4'h3);
        wait_start_a(10);
        repeat (15) step();
        chk("timeout_not_yet", 32'(toerr_a), 32'd0);
        step();
        chk("timeout_set", 32'(toerr_a), 32'd1);
        wait_idle_a(200);
        chk("to_len", 32'(qa.size() - base), 32'd3);
        if (qa.size() - base == 3) begin
            chk("to_byte1", 32'(qa[base + 1]), 32'hBE);
            chk("to_byte2", 32'(qa[base + 2]), 32'h03);
        end
        chk("timeout_sticky", 32'(toerr_a), 32'd1);
        clr_a = 1'b1; step(); clr_a = 1'b0;
        chk("timeout_clear", 32'(toerr_a), 32'd0);
        never_a = 1'b0;

        // Reset during the second byte, with a result pending
        pulse_a(16'h1111, 4'h0);
        wait_start_a(10);
        pulse_a(16'h2222, 4'h0);
        wait_start_a(40);
        reset = 1'b0;
        step();
        chk("mid_rst_start", 32'(tx_start_a), 32'd0);
        chk("mid_rst_data",  32'(tx_data_a),  32'd0);
        chk("mid_rst_busy",  32'(busy_a),     32'd0);
        reset = 1'b1;
        s0 = sc.size();
        repeat (30) step();
        chk("no_start_after_rst", 32'(sc.size() - s0), 32'd0);
        chk("idle_after_rst", 32'(busy_a), 32'd0);

        // tx_busy high at capture holds off the start
        force_busy_a = 1'b1;
        s0 = sc.size();
        pulse_a(16'h00AA, 4'h0);
        repeat (5) step();
        chk("held_no_start", 32'(sc.size() - s0), 32'd0);
        chk("held_tx_start", 32'(tx_start_a), 32'd0);
        force_busy_a = 1'b0;
        step();
        chk("released_start", 32'(tx_start_a), 32'd1);
        chk("released_data",  32'(tx_data_a),  32'hAA);
        wait_idle_a(200);

        // Instance B: MSB first, no flags byte
        result_b = 16'h1234; rv_b = 1'b1;
        step();
        rv_b = 1'b0;
        n = 0;
        while (busy_b && n < 200) begin step(); n++; end
        chk("b_idle_wait", 32'(busy_b), 32'd0);
        step();
        chk("b_len", 32'(qb.size()), 32'd2);
        if (qb.size() == 2) begin
            chk("b_byte0", 32'(qb[0]), 32'h12);
            chk("b_byte1", 32'(qb[1]), 32'h34);
        end

        chk("protocol", 32'(proto_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
